div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage of the 5-stage MIPS pipeline. Serves DIV and DIVU.
- Drives `stall`, which the hazard logic inverts into `en` for the IF/ID and ID/EX pipeline registers. This holds the instruction in EX until the result is ready.
- Quotient goes to LO and remainder to HI, written through the EX/MEM register.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  EX holds a DIV/DIVU instruction; held high until the instruction leaves EX.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- annul  input  1  flush of the EX instruction (exception/redirect); aborts the operation.
- dividend  input  WIDTH  rs operand.
- divisor  input  WIDTH  rt operand.
- stall  output  1  pipeline must hold; combinational from state/start/annul.
- valid  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  WIDTH  registered result for LO.
- remainder  output  WIDTH  registered result for HI.

Behaviour:
- Reset:
  - state=IDLE, counter=0.
  - quotient=0, remainder=0, valid=0.
  - Internal operand/sign registers = 0.
- States are IDLE, BUSY, DONE.
- IDLE:
  - On an edge with start=1 and annul=0, latch |dividend|, |divisor| and the sign flags (signed mode only), and clear the partial remainder and counter.
  - If divisor == 0, go to DONE; otherwise go to BUSY.
  - start is sampled only in IDLE.
- BUSY:
  - One restoring iteration per edge: shift the remainder:quotient pair left by 1, trial-subtract the divisor, and keep the difference if it is non-negative (WIDTH+1-bit compare), setting the quotient LSB.
  - The counter increments each iteration. After the WIDTH-th iteration (counter == WIDTH-1 at the edge), go to DONE and register the sign-corrected results.
- DONE: valid=1 for exactly this cycle, then IDLE at the next edge. start is ignored in DONE, because the same instruction is still in EX.
- Latency: start sampled at edge E0, BUSY edges E1..E_WIDTH, valid high in the cycle after E_WIDTH. That is WIDTH+2 cycles of instruction residency in EX, including the start cycle.
- stall equation: stall = (state==IDLE & start & ~annul) | (state==BUSY & ~annul). stall=0 in DONE, so the instruction advances at the end of the DONE cycle with the results.
- Sign rules (signed mode):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned mode performs no correction.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (natural wrap, no trap).
- Divide by zero: quotient = all-ones and remainder = dividend as presented. This holds in both modes; no exception is raised.
- annul:
  - In any state, annul forces IDLE at the next edge, with no valid pulse.
  - quotient/remainder keep their previous values.
  - annul takes priority over start in the same cycle.
- rst mid-operation: immediate return to reset values at the next edge; no valid.
- Outputs quotient/remainder hold their last values until the next DONE.

Decomposition:
- Shared package (cpu_defs):
  - State enum DIV_IDLE/DIV_BUSY/DIV_DONE (2-bit).
  - DIV_WIDTH=32.
  - The divide-by-zero result constant.
- Sub-module div_step (combinational): one restoring iteration. Inputs are partial remainder, quotient and divisor; outputs are the next remainder/quotient. It keeps the FSM file small.
- The abs/negate helpers live in div_unit.

Test Plan:
1. DIVU, dividend=100, divisor=7, start held high -> stall high for 33 cycles, valid pulse in cycle 34; quotient=14, remainder=2; stall=0 in the valid cycle.
2. DIV, 0xFFFFFF9C (-100) / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100 / 0xFFFFFFF9 (-7) -> quotient=-14, remainder=2.
3. DIV, 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU, 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
4. Divide by zero (both modes), dividend=0x12345678 -> valid pulse two cycles after start (IDLE->DONE); quotient=0xFFFFFFFF, remainder=0x12345678; stall only during the start cycle.
5. annul asserted 10 cycles into BUSY -> next cycle state=IDLE, stall=0, no valid, outputs unchanged. A fresh start of 9/2 afterwards gives quotient=4, remainder=1.
6. rst asserted mid-BUSY, and start held through DONE -> all outputs 0 after reset edge. start held high through DONE does not retrigger: exactly one valid pulse per operation.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared pipeline definitions: divider FSM states, datapath width and
// the fixed divide-by-zero quotient.
package cpu_defs;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // LO value written for a zero divisor; HI receives the raw dividend.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on magnitudes: shift remainder:quotient
// left, trial-subtract the divisor and keep the difference when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // The MSB of the WIDTH+1-bit difference is the borrow of the trial subtract.
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// EX-stage multi-cycle DIV/DIVU unit: holds the pipeline via stall while
// iterating, then presents quotient (LO) and remainder (HI) for one cycle.
module div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             last_iter;
  logic             divisor_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (dvs_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  assign last_iter    = (cnt == CNT_W'(WIDTH - 1));
  assign divisor_zero = (divisor == '0);
  assign valid        = (state == DIV_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start && !annul) begin
          stall      = 1'b1;
          state_next = divisor_zero ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (annul) begin
          state_next = DIV_IDLE;
        end else begin
          stall = 1'b1;
          if (last_iter) state_next = DIV_DONE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !annul) begin
            cnt       <= '0;
            rem_reg   <= '0;
            quo_reg   <= mag(dividend, is_signed);
            dvs_reg   <= mag(divisor, is_signed);
            neg_q_reg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_reg <= is_signed & dividend[WIDTH-1];
            // Zero divisor skips iteration, so its result is fixed right here.
            if (divisor_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        DIV_BUSY: begin
          if (!annul) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt     <= cnt + CNT_W'(1);
            if (last_iter) begin
              quotient  <= neg_q_reg ? negate(quo_step) : quo_step;
              remainder <= neg_r_reg ? negate(rem_step) : rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
